// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
//
// Parametrised multi-port register file for the decode stage of the
// pipelined datapath. It has one write port and NUM_RD independent read
// ports. Options cover write-to-read bypass, a hardwired zero register and
// a registered read stage. Every output is actively driven; there are no
// tristate bitlines.
//
// Parameters:
//   DATA_W  - bits per register
//   ADDR_W  - address bits, depth = 2**ADDR_W
//   NUM_RD  - number of read ports (1..4)
//   BYPASS  - 1: a same-cycle write is forwarded to a matching read
//   ZERO_R0 - 1: register 0 reads as zero and ignores writes
//   RD_LAT  - 0: combinational read, 1: registered read
//
// Ports:
//   clk      - clock; all state updates on the rising edge
//   rst      - synchronous active-high reset; clears the array and read regs
//   wr_en    - write enable
//   wr_addr  - write register index
//   wr_data  - write data
//   rd_en    - per-port read enable
//   rd_addr  - packed read indices, port p at [p*ADDR_W +: ADDR_W]
//   rd_data  - packed read data, port p at [p*DATA_W +: DATA_W]
//   rd_valid - per-port data valid
// ---------------------------------------------------------------------------
module reg_file_param #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int NUM_RD  = 2,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0,
    parameter int RD_LAT  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_valid
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]        mem [DEPTH];
    logic                     wr_to_zero;
    logic [NUM_RD*DATA_W-1:0] rd_value;

    // Writes to register 0 are discarded when it is hardwired to zero.
    assign wr_to_zero = (ZERO_R0 != 0) && (wr_addr == '0);

    // Storage array. Reset clears every entry and takes priority over a
    // concurrent write, which is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && !wr_to_zero) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Per-port read value. Priority: disabled port, zero register, bypass,
    // then array contents. Bypass is suppressed while rst is high, because
    // the write it would forward is being dropped by the reset.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] value;

        assign addr = rd_addr[p*ADDR_W +: ADDR_W];

        always_comb begin
            value = '0;
            if (!rd_en[p]) begin
                value = '0;
            end else if ((ZERO_R0 != 0) && (addr == '0)) begin
                value = '0;
            end else if ((BYPASS != 0) && wr_en && !rst && (wr_addr == addr)) begin
                value = wr_data;
            end else begin
                value = mem[addr];
            end
        end

        assign rd_value[p*DATA_W +: DATA_W] = value;
    end

    // Output stage. The registered variant samples the read value and rd_en
    // at the edge; reset discards whatever read was in flight.
    if (RD_LAT == 0) begin : g_comb_out
        assign rd_data  = rd_value;
        assign rd_valid = rd_en;
    end else begin : g_reg_out
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data  <= '0;
                rd_valid <= '0;
            end else begin
                rd_data  <= rd_value;
                rd_valid <= rd_en;
            end
        end
    end

endmodule
